// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the register file's single write port, with registered
// write outputs and a busy scoreboard for destinations reserved by long-latency ops.
module regfile_wb_arbiter #(
  parameter int NREQ = 3,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 hold,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  output logic                 RegWre,
  output logic [AW-1:0]        WriteReg,
  output logic [DW-1:0]        WriteData,
  output logic [(1<<AW)-1:0]   busy,
  output logic                 rsv_conflict
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: requester i raises req_valid[i] and holds addr/data stable; a write
  // transfers on the posedge where req_valid[i] & req_ready[i]. Ready never waits on valid
  // of the same requester being dropped, and busy never gates ready.
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      winner;
  logic [PW-1:0]      nextPtr;
  logic               found;
  logic [PW:0]        scanIdx;
  logic               xfer;
  logic [AW-1:0]      selAddr;
  logic [DW-1:0]      selData;
  logic               clearHit;
  logic               setHit;
  logic               conflictNext;
  logic [(1<<AW)-1:0] busyNext;

  // Scan from ptr upward, wrapping at NREQ; first valid requester wins.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    scanIdx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scanIdx = {1'b0, ptr} + (PW+1)'(k);
      if (scanIdx >= (PW+1)'(NREQ)) scanIdx = scanIdx - (PW+1)'(NREQ);
      if (!found && req_valid[scanIdx[PW-1:0]]) begin
        found  = 1'b1;
        winner = scanIdx[PW-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (RST && !hold && found) req_ready = NREQ'(1) << winner;
  end

  assign xfer    = |(req_valid & req_ready);
  assign nextPtr = (winner == PW'(NREQ-1)) ? '0 : winner + 1'b1;

  always_comb begin
    selAddr = '0;
    selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        selAddr = req_addr[i*AW +: AW];
        selData = req_data[i*DW +: DW];
      end
    end
  end

  // Set is applied after clear so a same-cycle reservation survives the writeback.
  assign clearHit = xfer && (selAddr != '0);
  assign setHit   = rsv_valid && (rsv_addr != '0);

  always_comb begin
    busyNext = busy;
    if (clearHit) busyNext[selAddr] = 1'b0;
    if (setHit)   busyNext[rsv_addr] = 1'b1;
    busyNext[0] = 1'b0;
  end

  assign conflictNext = setHit && busy[rsv_addr] && !(clearHit && (selAddr == rsv_addr));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ptr          <= '0;
      RegWre       <= 1'b0;
      WriteReg     <= '0;
      WriteData    <= '0;
      busy         <= '0;
      rsv_conflict <= 1'b0;
    end else begin
      RegWre       <= 1'b0;
      busy         <= busyNext;
      rsv_conflict <= conflictNext;
      if (xfer) begin
        ptr       <= nextPtr;
        WriteReg  <= selAddr;
        WriteData <= selData;
        RegWre    <= (selAddr != '0);
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: expected writes go into a queue, a negedge
// monitor pops one per RegWre cycle; a behavioural register file closes the loop.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic                      clk;
  logic                      RST;
  logic                      hold;
  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][AW-1:0]   req_addr;
  logic [NREQ-1:0][DW-1:0]   req_data;
  logic [NREQ-1:0]           req_ready;
  logic                      rsv_valid;
  logic [AW-1:0]             rsv_addr;
  logic                      RegWre;
  logic [AW-1:0]             WriteReg;
  logic [DW-1:0]             WriteData;
  logic [(1<<AW)-1:0]        busy;
  logic                      rsv_conflict;

  logic [AW+DW-1:0] exp_q[$];
  int n_cmp;
  int n_err;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .CLK(clk), .RST(RST), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rsv_valid(rsv_valid), .rsv_addr(rsv_addr),
    .RegWre(RegWre), .WriteReg(WriteReg), .WriteData(WriteData),
    .busy(busy), .rsv_conflict(rsv_conflict)
  );

  // behavioural register file: negedge write, combinational read
  logic [DW-1:0] rf [1<<AW];
  logic [AW-1:0] ReadReg1;
  logic [DW-1:0] ReadData1;
  always @(negedge clk) if (RegWre) rf[WriteReg] <= WriteData;
  assign ReadData1 = (ReadReg1 == '0) ? '0 : rf[ReadReg1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i] = a;
    req_data[i] = d;
  endtask

  // monitor: every registered write must match the head of the expected queue
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (RST && RegWre) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got reg %0d data %0h expected no write", WriteReg, WriteData);
      end else begin
        e = exp_q.pop_front();
        check("write_port", {27'd0, WriteReg, WriteData}, {27'd0, e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [(1<<AW)-1:0] busy_before;
    n_cmp = 0;
    n_err = 0;
    RST = 1'b0; hold = 1'b0; req_valid = '0; req_addr = '0; req_data = '0;
    rsv_valid = 1'b0; rsv_addr = '0; ReadReg1 = 5'd5;

    // reset state
    #1;
    check("rst_regwre", RegWre, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 0);
    @(negedge clk); @(negedge clk); #2 RST = 1'b1;

    // round-robin with all three requesters valid
    @(negedge clk);
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'hAAAA_0001);
    set_req(1, 5'd2, 32'hBBBB_0002);
    set_req(2, 5'd3, 32'hCCCC_0003);
    for (int r = 0; r < 2; r++) begin
      push_exp(5'd1, 32'hAAAA_0001);
      push_exp(5'd2, 32'hBBBB_0002);
      push_exp(5'd3, 32'hCCCC_0003);
    end
    for (int i = 0; i < 6; i++) begin
      #1 check("rr_ready", req_ready, 64'(3'b001 << (i % 3)));
      @(negedge clk);
    end
    req_valid = '0;

    // write to register 0: handshake completes, no write, busy untouched
    busy_before = busy;
    req_valid = 3'b010;
    set_req(1, 5'd0, 32'hDEAD_BEEF);
    #1 check("r0_ready", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0;
    check("r0_regwre", RegWre, 0);
    check("r0_busy", busy, busy_before);
    #1 check("r0_ready_after", req_ready, 0);

    // scoreboard: reserve, conflict, clear, same-cycle set-wins
    @(negedge clk);
    rsv_valid = 1'b1; rsv_addr = 5'd7;
    @(negedge clk);
    rsv_valid = 1'b0;
    check("sb_set", busy[7], 1);
    check("sb_no_conflict", rsv_conflict, 0);
    rsv_valid = 1'b1;
    @(negedge clk);
    rsv_valid = 1'b0;
    check("sb_conflict", rsv_conflict, 1);
    check("sb_still_busy", busy[7], 1);
    @(negedge clk);
    check("sb_conflict_pulse", rsv_conflict, 0);
    req_valid = 3'b010;
    set_req(1, 5'd7, 32'h0000_0777);
    push_exp(5'd7, 32'h0000_0777);
    #1 check("sb_wr_ready", req_ready, 3'b010);
    @(negedge clk);
    req_valid = '0;
    check("sb_clear", busy[7], 0);
    rsv_valid = 1'b1;
    @(negedge clk);
    rsv_valid = 1'b0;
    check("sb_reset7", busy[7], 1);
    req_valid = 3'b010;
    set_req(1, 5'd7, 32'h0000_0888);
    push_exp(5'd7, 32'h0000_0888);
    rsv_valid = 1'b1;
    @(negedge clk);
    req_valid = '0;
    rsv_valid = 1'b0;
    check("sb_set_wins", busy[7], 1);
    check("sb_set_wins_noconf", rsv_conflict, 0);

    // hold for 4 cycles; pointer sits at 2 so requester 2 must win afterwards
    hold = 1'b1;
    req_valid = 3'b101;
    set_req(0, 5'd4, 32'h0000_0044);
    set_req(2, 5'd6, 32'h0000_0066);
    for (int i = 0; i < 4; i++) begin
      #1 check("hold_ready", req_ready, 0);
      @(negedge clk);
      check("hold_regwre", RegWre, 0);
    end
    hold = 1'b0;
    push_exp(5'd6, 32'h0000_0066);
    push_exp(5'd4, 32'h0000_0044);
    #1 check("hold_release_ready", req_ready, 3'b100);
    @(negedge clk);
    req_valid = 3'b001;
    #1 check("hold_next_ready", req_ready, 3'b001);
    @(negedge clk);
    req_valid = '0;

    // integration: req2 writes r5, register file returns it after the negedge
    req_valid = 3'b100;
    set_req(2, 5'd5, 32'h1234_5678);
    push_exp(5'd5, 32'h1234_5678);
    #1 check("int_ready", req_ready, 3'b100);
    @(negedge clk);
    req_valid = '0;
    #1 check("int_readdata", ReadData1, 32'h1234_5678);

    // reset mid-stream with everyone valid; first grant afterwards goes to req0
    @(negedge clk);
    req_valid = 3'b111;
    set_req(0, 5'd1, 32'hAAAA_0001);
    set_req(1, 5'd2, 32'hBBBB_0002);
    set_req(2, 5'd3, 32'hCCCC_0003);
    push_exp(5'd1, 32'hAAAA_0001);
    @(negedge clk);
    #2 RST = 1'b0;
    #1;
    check("mrst_regwre", RegWre, 0);
    check("mrst_writereg", WriteReg, 0);
    check("mrst_writedata", WriteData, 0);
    check("mrst_busy", busy, 0);
    check("mrst_conflict", rsv_conflict, 0);
    check("mrst_ready", req_ready, 0);
    @(negedge clk);
    #2 RST = 1'b1;
    push_exp(5'd1, 32'hAAAA_0001);
    #1 check("mrst_first_grant", req_ready, 3'b001);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between `NREQ` writeback requesters: the multi-cycle datapath writeback, the long-latency mult/div unit and the debug port. Requests are granted round-robin over a valid/ready handshake. The block drives `RegWre`/`WriteReg`/`WriteData` from registers so they are stable across the register file's negedge write. It also keeps a busy scoreboard of destination registers reserved by in-flight long-latency operations, which the control unit uses for hazard stalls.

## Interface
- `NREQ`, default 3: number of requesters; index 0 is datapath, 1 is mult/div, 2 is debug.
- `AW`, default 5: register address width.
- `DW`, default 32: data width.

- `CLK` in 1: clock; all state updates on posedge.
- `RST` in 1: reset, asynchronous, active-low.
- `hold` in 1: when 1, no grant this cycle.
- `req_valid` in NREQ: request i presents a write.
- `req_addr` in NREQ*AW: destination for request i, in slice i.
- `req_data` in NREQ*DW: data for request i, in slice i.
- `req_ready` out NREQ: one-hot grant, combinational.
- `rsv_valid` in 1: reserve destination `rsv_addr` (long op issued).
- `rsv_addr` in AW: register to reserve.
- `RegWre` out 1: register file write enable, registered.
- `WriteReg` out AW: register file write address, registered.
- `WriteData` out DW: register file write data, registered.
- `busy` out 2^AW: scoreboard; bit r=1 means register r has a pending write. Bit 0 is always 0.
- `rsv_conflict` out 1: one-cycle pulse when a reserve targets an already busy register.

## Operation
**Arbitration**
- Pointer `ptr` (0..NREQ-1) has top priority.
- Winner is the first i with `req_valid[i]=1`, scanning ptr, ptr+1, … modulo NREQ.
- `req_ready[winner]=1`; all other ready bits are 0.
- `req_ready` is all-zero when `hold=1`, when no valid request exists, or while RST=0.
- Transfer occurs when `req_valid[i] & req_ready[i]` at posedge.
- On transfer, `ptr` becomes (winner+1) mod NREQ. Otherwise `ptr` holds.
- Requesters must hold valid/addr/data stable until transfer. Dropping valid early is illegal and produces no write.

**Output register**
- On transfer: `WriteReg`←addr, `WriteData`←data, `RegWre`←(addr≠0).
- Without transfer: `RegWre`←0; `WriteReg`/`WriteData` hold.
- A write to register 0 completes the handshake but never asserts `RegWre`.

**Scoreboard**, updated on each posedge:
- Clear: on transfer with addr≠0, `busy[addr]`←0.
- Set: if `rsv_valid` and `rsv_addr`≠0, `busy[rsv_addr]`←1.
- If set and clear hit the same address in the same cycle, set wins: the new reservation survives.
- Reserving an already-busy register, not being cleared that cycle, leaves it busy and pulses `rsv_conflict` for one cycle.
- `rsv_addr`=0 is ignored.
- Requests are never blocked by `busy`. Stalling on `busy` is the control unit's job.

**Reset (RST=0, immediate)**
- `RegWre`=0, `WriteReg`=0, `WriteData`=0, `busy`=0, `rsv_conflict`=0, `ptr`=0, `req_ready`=0.
- Reset during a pending request discards it; no write is issued.
- Requesters re-present after reset release.

## Timing
- Transfer at posedge k, then `RegWre`/`WriteReg`/`WriteData` valid from k until posedge k+1. The register file captures at the negedge between them, so write latency is half a cycle after the transfer edge.
- Back-to-back transfers every cycle are allowed; `RegWre` then stays high continuously.
- `busy` reflects a transfer or reserve from posedge k onward. Readers see the update in cycle k+1's combinational logic.
- Fairness: with all NREQ valid and `hold`=0, each requester is granted exactly once every NREQ cycles. Maximum wait is NREQ-1 grants.
- `hold` only gates `req_ready`. It does not freeze an output write already registered.
- `rsv_conflict` is registered and high for exactly one cycle per conflicting reserve.

## Test plan
- **Reset:** RST=0 mid-stream with `req_valid`=3'b111. Required: all outputs 0 immediately, `req_ready`=0. After release, first grant goes to requester 0.
- **Round-robin:** all three valid continuously with addrs 1/2/3 and data A/B/C. Required: `WriteReg` sequence 1,2,3,1,2,3 on consecutive cycles, `RegWre` constantly 1.
- **Register 0:** req1 writes addr 0, data 32'hDEADBEEF. Required: `req_ready[1]`=1 for one cycle, `RegWre` stays 0, `busy` unchanged.
- **Scoreboard:**
  - `rsv_valid` with addr 7 gives `busy[7]`=1.
  - Later, req1 writes addr 7, which clears `busy[7]` on that edge.
  - A reserve of 7 in the same cycle as that write leaves `busy[7]`=1.
  - A second reserve of 7 while busy pulses `rsv_conflict` once.
- **Hold:** `hold`=1 for 4 cycles with req0 valid. Required: `req_ready`=0 and `RegWre`=0 for those cycles. Grant comes on the first cycle after `hold` falls, with `ptr` unchanged.
- **Integration:** connect to the register file and write 32'h12345678 to r5 via req2. Required: ReadData1 with ReadReg1=5 returns 32'h12345678 after the following negedge.
